// File: rtl/scan_segment_driver.sv
// Multiplexed seven-segment scanner with frame-synchronous double buffering,
// leading-zero blanking, per-digit blink, decimal points and selectable polarity.
module scan_segment_driver #(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 4096,
    parameter int BLINK_DIV  = 64,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   time_data,
    input  logic                  data_valid,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  lz_blank,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    // XOR masks that apply output polarity; also the "everything off" levels.
    localparam logic [7:0]        SEG_OFF = {8{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{ACTIVE_LOW}};

    logic [SCAN_W-1:0]   scan_cnt;
    logic [IDX_W-1:0]    digit_idx;
    logic [4*DIGITS-1:0] staging;
    logic [4*DIGITS-1:0] shadow;
    logic                pending;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                blink_phase;

    logic                scan_wrap;
    logic                frame_end;

    logic                above_zero;
    logic [3:0]          cur_nibble;
    logic                cur_lz;
    logic                cur_dp;
    logic                cur_blink;
    logic [DIGITS-1:0]   an_next;
    logic [7:0]          seg_next;

    function automatic logic [6:0] decode7(input logic [3:0] n);
        case (n)
            4'd0:    decode7 = 7'h3F;
            4'd1:    decode7 = 7'h06;
            4'd2:    decode7 = 7'h5B;
            4'd3:    decode7 = 7'h4F;
            4'd4:    decode7 = 7'h66;
            4'd5:    decode7 = 7'h6D;
            4'd6:    decode7 = 7'h7D;
            4'd7:    decode7 = 7'h07;
            4'd8:    decode7 = 7'h7F;
            4'd9:    decode7 = 7'h6F;
            default: decode7 = 7'h40;
        endcase
    endfunction

    assign scan_wrap = (scan_cnt == SCAN_LAST);
    assign frame_end = scan_wrap && (digit_idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_wrap) begin
            scan_cnt  <= '0;
            digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        end else begin
            scan_cnt  <= scan_cnt + 1'b1;
        end
    end

    // A strobe on the frame boundary bypasses staging so it is never a frame late.
    always_ff @(posedge clk) begin
        if (rst) begin
            staging <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else begin
            if (data_valid) begin
                staging <= time_data;
            end
            if (frame_end) begin
                pending <= 1'b0;
                if (data_valid) begin
                    shadow <= time_data;
                end else if (pending) begin
                    shadow <= staging;
                end
            end else if (data_valid) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_end) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt   <= blink_cnt + 1'b1;
            end
        end
    end

    // Scan from the top digit down so above_zero tracks "this and all higher nibbles are 0".
    always_comb begin
        above_zero = 1'b1;
        cur_nibble = '0;
        cur_lz     = 1'b0;
        cur_dp     = 1'b0;
        cur_blink  = 1'b0;
        an_next    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            above_zero = above_zero && (shadow[4*k +: 4] == 4'd0);
            if (digit_idx == IDX_W'(k)) begin
                cur_nibble = shadow[4*k +: 4];
                cur_lz     = lz_blank && (k != 0) && above_zero;
                cur_dp     = dp_mask[k];
                cur_blink  = blink_mask[k];
                an_next[k] = 1'b1;
            end
        end
    end

    always_comb begin
        seg_next = 8'h00;
        if (!(cur_blink && blink_phase)) begin
            seg_next = {cur_dp, cur_lz ? 7'h00 : decode7(cur_nibble)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= SEG_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_next ^ SEG_OFF;
            an         <= an_next ^ AN_OFF;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_scan_segment_driver.sv
// Scoreboard bench: two 4-digit drivers (active-high and active-low) share one
// stimulus stream; each cycle's expected outputs are queued and checked a cycle later.
module tb_scan_segment_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_valid;
    logic        lz_blank;
    logic [15:0] time_data;
    logic [3:0]  dp_mask;
    logic [3:0]  blink_mask;

    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_done;
    logic [7:0]  seg_n;
    logic [3:0]  an_n;
    logic        frame_done_n;

    always #5 clk = ~clk;

    scan_segment_driver #(
        .DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(1'b0)
    ) dut_high (
        .clk(clk), .rst(rst), .time_data(time_data), .data_valid(data_valid),
        .dp_mask(dp_mask), .blink_mask(blink_mask), .lz_blank(lz_blank),
        .seg(seg), .an(an), .frame_done(frame_done)
    );

    scan_segment_driver #(
        .DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(1'b1)
    ) dut_low (
        .clk(clk), .rst(rst), .time_data(time_data), .data_valid(data_valid),
        .dp_mask(dp_mask), .blink_mask(blink_mask), .lz_blank(lz_blank),
        .seg(seg_n), .an(an_n), .frame_done(frame_done_n)
    );

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] an;
        logic       fd;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc;
    logic [15:0] shown;
    logic [15:0] staged;
    logic        pend;
    logic [6:0]  seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: observed %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    task automatic compareSample();
        exp_t       e;
        logic [7:0] seg_inv;
        logic [3:0] an_inv;
        if (sb.size() == 0) return;
        e       = sb.pop_front();
        seg_inv = ~e.seg;
        an_inv  = ~e.an;
        checkOutput("seg",          32'(seg),          32'(e.seg));
        checkOutput("an",           32'(an),           32'(e.an));
        checkOutput("frame_done",   32'(frame_done),   32'(e.fd));
        checkOutput("seg_n",        32'(seg_n),        32'(seg_inv));
        checkOutput("an_n",         32'(an_n),         32'(an_inv));
        checkOutput("frame_done_n", 32'(frame_done_n), 32'(e.fd));
    endtask

    // Drive one cycle of stimulus and queue what the registered outputs must show next cycle.
    task automatic applyStimulus(input logic r, input logic dv, input logic [15:0] td,
                                 input logic [3:0] dp, input logic [3:0] bm, input logic lz);
        exp_t e;
        int   d;
        int   f;
        logic lzb;
        @(negedge clk);
        compareSample();
        rst        = r;
        data_valid = dv;
        time_data  = td;
        dp_mask    = dp;
        blink_mask = bm;
        lz_blank   = lz;
        e = '0;
        if (r) begin
            shown = 16'h0;
            pend  = 1'b0;
            cyc   = 0;
        end else begin
            d    = (cyc / 4) % 4;
            f    = cyc / 16;
            lzb  = lz && (d != 0) && ((shown >> (4 * d)) == 16'h0);
            e.an = 4'b0001 << d;
            e.fd = (cyc % 16 == 15);
            if (((f / 2) % 2 == 1) && bm[d])
                e.seg = 8'h00;
            else
                e.seg = {dp[d], lzb ? 7'h00 : seg_tbl[shown[4*d +: 4]]};
            if (dv) begin
                staged = td;
                pend   = 1'b1;
            end
            if (cyc % 16 == 15) begin
                if (dv) shown = td;
                else if (pend) shown = staged;
                pend = 1'b0;
            end
            cyc++;
        end
        sb.push_back(e);
    endtask

    task automatic runFrame(input logic [3:0] dp, input logic [3:0] bm, input logic lz,
                            input int s1_off, input logic [15:0] s1,
                            input int s2_off, input logic [15:0] s2, input int rst_off);
        for (int i = 0; i < 16; i++) begin
            if (i == rst_off) begin
                applyStimulus(1'b1, 1'b0, 16'h0, dp, bm, lz);
                return;
            end else if (i == s1_off) begin
                applyStimulus(1'b0, 1'b1, s1, dp, bm, lz);
            end else if (i == s2_off) begin
                applyStimulus(1'b0, 1'b1, s2, dp, bm, lz);
            end else begin
                applyStimulus(1'b0, 1'b0, 16'h0, dp, bm, lz);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        data_valid = 1'b0;
        time_data  = 16'h0;
        dp_mask    = 4'h0;
        blink_mask = 4'h0;
        lz_blank   = 1'b0;
        shown      = 16'h0;
        staged     = 16'h0;
        pend       = 1'b0;
        cyc        = 0;

        repeat (3) applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);

        runFrame(4'h0, 4'h0, 1'b0,  0, 16'h1234, -1, 16'h0, -1);
        runFrame(4'h0, 4'h0, 1'b0,  5, 16'h5678, -1, 16'h0, -1);
        runFrame(4'h0, 4'h0, 1'b0,  2, 16'h9999,  9, 16'h1111, -1);
        runFrame(4'h0, 4'h0, 1'b0, 15, 16'h00A0, -1, 16'h0, -1);
        runFrame(4'h0, 4'h0, 1'b1,  6, 16'h0007, -1, 16'h0, -1);
        runFrame(4'h0, 4'h0, 1'b1,  3, 16'h0000, -1, 16'h0, -1);
        runFrame(4'h0, 4'h0, 1'b1, 12, 16'h1234, -1, 16'h0, -1);
        runFrame(4'b0100, 4'b0011, 1'b0, -1, 16'h0, -1, 16'h0, -1);
        runFrame(4'b0100, 4'b0011, 1'b0, -1, 16'h0, -1, 16'h0, -1);
        runFrame(4'b0100, 4'b0011, 1'b0, -1, 16'h0, -1, 16'h0, -1);
        runFrame(4'b0111, 4'b0011, 1'b0,  4, 16'h8888, -1, 16'h0, -1);
        runFrame(4'h0, 4'h0, 1'b0,  3, 16'h9999, -1, 16'h0,  9);
        runFrame(4'h0, 4'h0, 1'b0, -1, 16'h0, -1, 16'h0, -1);
        runFrame(4'h0, 4'h0, 1'b0, -1, 16'h0, -1, 16'h0, -1);

        @(negedge clk);
        compareSample();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
